// File: rtl/ps2_pkg.sv
// Shared types and frame constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_t;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // PS/2 uses odd parity over the data byte plus the parity bit.
  function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Synchronous FIFO with a registered show-ahead head; the head holds its
// last value once the FIFO drains. Pop-before-push when full with both.
module kbd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_dout
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_head;

  logic             w_pop_ok;
  logic             w_push_ok;
  logic [AW:0]      w_wr_next;
  logic [AW:0]      w_rd_next;
  logic [WIDTH-1:0] w_head_next;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);
  assign w_wr_next = r_wr_ptr + {{AW{1'b0}}, w_push_ok};
  assign w_rd_next = r_rd_ptr + {{AW{1'b0}}, w_pop_ok};
  assign o_dout    = r_head;

  // The new head is either the byte being written into the head slot or an
  // already stored entry; an empty FIFO keeps showing the previous head.
  always_comb begin
    w_head_next = r_head;
    if (w_rd_next != w_wr_next) begin
      if (w_push_ok && (w_rd_next[AW-1:0] == r_wr_ptr[AW-1:0]))
        w_head_next = i_din;
      else
        w_head_next = r_mem[w_rd_next[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok)
      r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_head   <= '0;
    end else begin
      r_wr_ptr <= w_wr_next;
      r_rd_ptr <= w_rd_next;
      r_head   <= w_head_next;
    end
  end

endmodule

// File: rtl/ps2_kbd.sv
// PS/2 keyboard receiver: synchronizers, frame FSM with timeout, scan-code FIFO.
// Optional macro PS2_PARITY_CHECK_EN discards frames with bad odd parity.
module ps2_kbd
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  input  logic       i_read_enable,
  output logic       o_ready,
  output logic       o_overflow,
  output logic [7:0] o_data
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;
  ps2_state_t             r_state, w_state_next;
  logic [2:0]             r_bit_cnt, w_bit_cnt_next;
  logic [DATA_BITS-1:0]   r_shreg, w_shreg_next;
  logic [TW-1:0]          r_to_cnt, w_to_next;
  logic                   r_overflow;

  logic w_fall;
  logic w_bit;
  logic w_push;
  logic w_frame_ok;
  logic w_full;
  logic w_empty;
  logic w_pop_ok;
  logic w_drop;

  // Synchronizers preset high so reset looks like an idle bus, not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_ps2_data};
      r_clk_prev  <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  assign w_fall = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
  assign w_bit  = r_data_sync[SYNC_STAGES-1];

`ifdef PS2_PARITY_CHECK_EN
  logic r_par;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_par <= 1'b0;
    else if (r_state == ST_PARITY && w_fall)
      r_par <= w_bit;
  end
  assign w_frame_ok = odd_parity_ok(r_shreg, r_par);
`else
  assign w_frame_ok = 1'b1;
`endif

  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    w_shreg_next   = r_shreg;
    w_to_next      = '0;
    w_push         = 1'b0;
    if (r_state != ST_IDLE && !w_fall)
      w_to_next = r_to_cnt + 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (w_fall && w_bit == START_BIT) begin
          w_state_next   = ST_DATA;
          w_bit_cnt_next = '0;
        end
      end
      ST_DATA: begin
        if (w_fall) begin
          w_shreg_next   = {w_bit, r_shreg[DATA_BITS-1:1]};
          w_bit_cnt_next = r_bit_cnt + 1'b1;
          if (r_bit_cnt == 3'(DATA_BITS - 1))
            w_state_next = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (w_fall)
          w_state_next = ST_STOP;
      end
      ST_STOP: begin
        if (w_fall) begin
          w_state_next = ST_IDLE;
          w_push       = (w_bit == STOP_BIT) && w_frame_ok;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    // A stalled keyboard clock abandons the partial frame.
    if (r_state != ST_IDLE && !w_fall && r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      w_state_next = ST_IDLE;
      w_to_next    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_to_cnt  <= '0;
    end else begin
      r_state   <= w_state_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_shreg   <= w_shreg_next;
      r_to_cnt  <= w_to_next;
    end
  end

  kbd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_shreg_next),
    .i_pop   (i_read_enable),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_dout  (o_data)
  );

  assign o_ready  = ~w_empty;
  assign w_pop_ok = i_read_enable & o_ready;
  assign w_drop   = w_push & w_full & ~w_pop_ok;

  // A drop in the same cycle as a clearing read leaves the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_overflow <= 1'b0;
    else if (w_drop)
      r_overflow <= 1'b1;
    else if (w_pop_ok)
      r_overflow <= 1'b0;
  end

  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_ps2_kbd.sv
// Directed + randomized bench for ps2_kbd against a queue-based model of the
// keyboard buffer; frames are driven bit by bit on the PS/2 pads.
module tb_ps2_kbd;

  localparam int DEPTH   = 8;
  localparam int SYNC    = 2;
  localparam int TIMEOUT = 200;
  localparam int HALF    = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       read_enable;
  logic       ready;
  logic       overflow;
  logic [7:0] data;

  int vectors    = 0;
  int miscompares = 0;

  logic [7:0] q[$];
  logic       m_ovf;
  logic [7:0] m_hold;

  always #5 clk = ~clk;

  ps2_kbd #(
    .FIFO_DEPTH     (DEPTH),
    .SYNC_STAGES    (SYNC),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_ps2_clk     (ps2_clk),
    .i_ps2_data    (ps2_data),
    .i_read_enable (read_enable),
    .o_ready       (ready),
    .o_overflow    (overflow),
    .o_data        (data)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  function automatic bit frame_ok(input logic [7:0] b, input logic par);
`ifdef PS2_PARITY_CHECK_EN
    return (($countones(b) + int'(par)) % 2) == 1;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [7:0] exp_data();
    return (q.size() > 0) ? q[0] : m_hold;
  endfunction

  task automatic model_push(input logic [7:0] b);
    if (q.size() < DEPTH) q.push_back(b);
    else m_ovf = 1'b1;
  endtask

  task automatic model_pop();
    if (q.size() > 0) begin
      m_hold = q.pop_front();
      m_ovf  = 1'b0;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_ready"}, {7'd0, ready}, {7'd0, q.size() > 0});
    chk({tag, "_ovf"}, {7'd0, overflow}, {7'd0, m_ovf});
    chk({tag, "_data"}, data, exp_data());
  endtask

  // Drives the first nbits of {stop, parity, byte, start}; optionally pops on
  // the exact cycle the DUT sees the last falling edge.
  task automatic send_bits(input logic [10:0] frame, input int nbits, input bit pop_at_last);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = frame[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (pop_at_last && i == nbits - 1) begin
        repeat (SYNC) @(negedge clk);
        read_enable = 1'b1;
        @(negedge clk);
        read_enable = 1'b0;
        repeat (HALF - SYNC - 1) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    @(negedge clk);
    ps2_data = 1'b1;
  endtask

  task automatic frame_txn(input string tag, input logic [7:0] b, input logic par,
                           input logic stop, input bit pop_at_stop);
    $display("frame %02h par=%0d stop=%0d pop=%0d", b, par, stop, pop_at_stop);
    send_bits({stop, par, b, 1'b0}, 11, pop_at_stop);
    if (pop_at_stop) model_pop();
    if (stop && frame_ok(b, par)) model_push(b);
    check_state(tag);
  endtask

  task automatic read_byte(input string tag);
    @(negedge clk);
    if (q.size() > 0) chk({tag, "_rd"}, data, q[0]);
    $display("read %02h ready=%0d", data, ready);
    read_enable = 1'b1;
    @(negedge clk);
    read_enable = 1'b0;
    model_pop();
    check_state(tag);
  endtask

  initial begin
    logic [7:0] b;
    logic       par;
    logic       stop;

    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; read_enable = 1'b0;
    m_ovf = 1'b0; m_hold = 8'h00;
    repeat (3) @(negedge clk);
    check_state("reset");
    rst = 1'b0;

    // 0x1C with exact one-cycle latency after the stop edge is seen
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 10, 1'b0);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (SYNC) @(negedge clk);
    chk("lat_before", {7'd0, ready}, 8'd0);
    @(negedge clk);
    chk("lat_ready", {7'd0, ready}, 8'd1);
    chk("lat_data", data, 8'h1C);
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    $display("frame 1c par=0 stop=1 pop=0");
    model_push(8'h1C);
    read_byte("pop1c");

    // 0xF0 with even overall parity
    frame_txn("badpar", 8'hF0, 1'b0, 1'b1, 1'b0);
    while (q.size() > 0) read_byte("badpar_drain");

    // nine frames, no reads: ninth is dropped
    for (int i = 1; i <= 9; i++) begin
      b = 8'(i);
      frame_txn("ovf_fill", b, ~^b, 1'b1, 1'b0);
    end
    chk("ovf_set", {7'd0, overflow}, 8'd1);
    for (int i = 0; i < 8; i++) read_byte("ovf_drain");

    // full FIFO, pop coincides with ninth stop edge
    for (int i = 1; i <= 8; i++) begin
      b = 8'(i);
      frame_txn("sim_fill", b, ~^b, 1'b1, 1'b0);
    end
    frame_txn("sim_pushpop", 8'h09, ~^8'h09, 1'b1, 1'b1);
    chk("sim_ovf", {7'd0, overflow}, 8'd0);
    for (int i = 0; i < 8; i++) read_byte("sim_drain");
    chk("sim_last", m_hold, 8'h09);
    chk("sim_last_dut", data, 8'h09);

    // partial frame then a stalled clock
    b = 8'h33;
    send_bits({1'b1, 1'b0, b, 1'b0}, 5, 1'b0);
    repeat (TIMEOUT + 50) @(negedge clk);
    frame_txn("timeout_5a", 8'h5A, ~^8'h5A, 1'b1, 1'b0);
    read_byte("timeout_pop");

    // async reset mid-frame with two bytes buffered
    frame_txn("rst_fill", 8'h11, ~^8'h11, 1'b1, 1'b0);
    frame_txn("rst_fill", 8'h22, ~^8'h22, 1'b1, 1'b0);
    send_bits({1'b1, 1'b0, 8'h44, 1'b0}, 4, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_ready", {7'd0, ready}, 8'd0);
    chk("rst_ovf", {7'd0, overflow}, 8'd0);
    chk("rst_data", data, 8'h00);
    q.delete(); m_ovf = 1'b0; m_hold = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    frame_txn("rst_29", 8'h29, ~^8'h29, 1'b1, 1'b0);
    read_byte("rst_pop");

    // randomized frames with occasional bad parity / stop and random reads
    for (int n = 0; n < 30; n++) begin
      b    = 8'($urandom);
      par  = ($urandom_range(0, 4) == 0) ? ^b : ~^b;
      stop = ($urandom_range(0, 9) != 0);
      frame_txn("rand", b, par, stop, ($urandom_range(0, 5) == 0));
      for (int k = $urandom_range(0, 2); k > 0; k--) read_byte("rand_rd");
    end
    while (q.size() > 0) read_byte("rand_drain");
    read_byte("rand_empty");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_kbd.md
Name: ps2_kbd

Overview:
- PS/2 keyboard receiver that produces the CPU-side keyboard interface consumed by the mmio block: ready / overflow / 8-bit data out, read_enable in.
- Samples the external PS/2 clock and data lines in the system clock domain, deframes 11-bit frames and buffers scan codes in a FIFO.
- The CPU pops scan codes through mmio loads.

Parameters:
- FIFO_DEPTH, 8, number of buffered scan codes; power of two, minimum 2.
- SYNC_STAGES, 2, flip-flop stages on ps2_clk and ps2_data; minimum 2.
- TIMEOUT_CYCLES, 100000, system cycles without a PS/2 falling edge before a partial frame is discarded.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- ps2_clk  input  1  raw PS/2 clock from the pad (asynchronous).
- ps2_data  input  1  raw PS/2 data from the pad (asynchronous).
- read_enable  input  1  pop request from mmio (kbd_read_enable); one pop per asserted cycle.
- ready  output  1  FIFO non-empty.
- overflow  output  1  sticky flag: a valid byte was dropped because the FIFO was full.
- data  output  8  FIFO head (show-ahead); valid when ready=1.

Behaviour:
- Reset (async, active-high):
  - FSM goes to IDLE; FIFO is emptied; bit counter and timeout counter go to 0.
  - ready=0, overflow=0, data=8'h00.
  - Synchronizers are preset to 1 (bus idle high).
  - Reset mid-frame discards the partial frame.
- Edge detect:
  - A falling edge is the synchronized ps2_clk going from 1 to 0 between consecutive clk cycles.
  - ps2_data is sampled from its synchronizer on the same cycle the edge is detected.
- FSM states:
  - IDLE: on a falling edge with data=0 (start bit), go to DATA with bit_cnt=0. A start bit of 1 is ignored; stay in IDLE.
  - DATA: shift data in LSB first, one bit per falling edge. After the 8th bit, go to PARITY.
  - PARITY: latch the parity bit on a falling edge, then go to STOP.
  - STOP: on a falling edge, if stop=1 and the frame is valid, push the byte, then go to IDLE. If stop=0, discard the frame and go to IDLE.
- Timeout: in any state other than IDLE, the counter increments every cycle and clears on each falling edge. When it reaches TIMEOUT_CYCLES-1, go to IDLE and discard the partial frame.
- Latency: ready rises on the cycle after the clk edge that detects the stop-bit falling edge, and data shows the byte on that same cycle.
- FIFO rules:
  - Push and pop on the same cycle when the FIFO is full: pop first, then push. The push succeeds and overflow is unchanged.
  - Push while full with no pop: the byte is dropped and overflow is set.
  - Pop while empty: ignored, with no pointer change.
  - Pointers wrap modulo FIFO_DEPTH; an extra MSB on each pointer distinguishes full from empty.
- overflow clears on any cycle with read_enable=1 and ready=1. If that same cycle also contains a push that is dropped, set wins.
- data holds its last value when the FIFO is empty.

Optional Feature:
- PS2_PARITY_CHECK_EN
  - Defined: a frame is valid only if the 8 data bits plus the parity bit contain an odd number of ones. Frames with bad parity are discarded silently.
  - Undefined: the parity bit is still consumed by the FSM, but is ignored. Every frame with stop=1 is pushed.

Decomposition:
- Package ps2_pkg:
  - FSM state enum (IDLE, DATA, PARITY, STOP).
  - Frame constants: DATA_BITS=8, START_BIT=1'b0, STOP_BIT=1'b1.
- One sub-module, kbd_fifo: synchronous FIFO with show-ahead output and push/pop/full/empty. Parameterized by depth and width.
- The FSM, synchronizers and timeout logic stay in ps2_kbd.

Test Plan:
- Frame for 0x1C: start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1 -> ready=1 and data=8'h1C one cycle after the stop edge. Then read_enable pulse for 1 cycle -> ready=0.
- Frame 0xF0 with parity 0 (bad):
  - With PS2_PARITY_CHECK_EN defined -> ready stays 0.
  - Without the macro -> data=8'hF0.
- Send 9 valid frames (0x01..0x09) with FIFO_DEPTH=8 and no reads -> overflow=1. Reading 8 times returns 0x01..0x08. overflow clears on the first read.
- Fill the FIFO to 8, then assert read_enable on the same cycle as the 9th frame's stop edge -> overflow=0, ready=1, and the last read returns 0x09.
- Send start plus 4 data bits, then stop the PS/2 clock for TIMEOUT_CYCLES -> FSM returns to IDLE. A following complete frame 0x5A is received correctly.
- Assert rst mid-frame after 3 data bits while the FIFO holds 2 bytes -> ready=0 and overflow=0 immediately (async). The next full frame 0x29 is received as the only entry.
